// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions: fixed-point coefficient helpers and the
// inverse Clarke sequencer state type.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2
    } inv_clarke_state_t;

    localparam longint COEF_SCALE = 64'sd1000000000;

    // Coefficients are kept as 9-digit integers so rounding stays exact in integer math.
    function automatic longint sqrt3_div_2(input int q_bits);
        return (64'sd866025404 * (longint'(1) <<< q_bits) + COEF_SCALE / 2) / COEF_SCALE;
    endfunction

    function automatic longint one_div_sqrt3(input int q_bits);
        return (64'sd577350269 * (longint'(1) <<< q_bits) + COEF_SCALE / 2) / COEF_SCALE;
    endfunction

endpackage

// File: rtl/sat_trunc.sv
// Signed width reduction: saturates when INV_CLARKE_SAT_EN is defined,
// otherwise keeps the low OUT_WIDTH bits (two's-complement wrap).
module sat_trunc #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 18
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

`ifdef INV_CLARKE_SAT_EN
    localparam logic signed [IN_WIDTH-1:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        dout = OUT_WIDTH'(din);
        if (din > MAX_V) begin
            dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (din < MIN_V) begin
            dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end
`else
    assign dout = OUT_WIDTH'(din);
`endif

endmodule

// File: rtl/inv_clarke.sv
// Inverse Clarke transform (alpha, beta) -> (a, b, c) with one shared multiplier.
// Build option INV_CLARKE_SAT_EN selects saturation of b and c instead of wrap.
//
// state | meaning
// IDLE  | waiting for start; inputs captured on accepted start
// MUL   | p = (beta_r * K) >>> Q_BITS registered
// SUM   | a, b, c registered, done pulsed
module inv_clarke
    import motor_ctrl_pkg::*;
#(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic                      start,
    output logic signed [D_WIDTH-1:0] a,
    output logic signed [D_WIDTH-1:0] b,
    output logic signed [D_WIDTH-1:0] c,
    output logic                      busy,
    output logic                      done
);

    localparam int P_W  = D_WIDTH + Q_BITS + 1;
    localparam int PR_W = D_WIDTH + 1;
    localparam int S_W  = D_WIDTH + 2;
    localparam logic signed [Q_BITS:0] K = (Q_BITS+1)'(sqrt3_div_2(Q_BITS));

    inv_clarke_state_t state, next_state;

    logic signed [D_WIDTH-1:0] alpha_r, beta_r;
    logic signed [PR_W-1:0]    p;
    logic signed [P_W-1:0]     prod;
    logic signed [S_W-1:0]     h_ext, p_ext, b_sum, c_sum;
    logic signed [D_WIDTH-1:0] b_fit, c_fit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MUL;
            MUL:     next_state = SUM;
            SUM:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    assign prod  = P_W'(beta_r) * P_W'(K);
    assign h_ext = S_W'(alpha_r >>> 1);
    assign p_ext = S_W'(p);
    assign b_sum = p_ext - h_ext;
    assign c_sum = -p_ext - h_ext;

    sat_trunc #(.IN_WIDTH(S_W), .OUT_WIDTH(D_WIDTH)) u_fit_b (.din(b_sum), .dout(b_fit));
    sat_trunc #(.IN_WIDTH(S_W), .OUT_WIDTH(D_WIDTH)) u_fit_c (.din(c_sum), .dout(c_fit));

    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_r <= '0;
            beta_r  <= '0;
            p       <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alpha_r <= alpha;
                        beta_r  <= beta;
                    end
                end
                MUL: p <= PR_W'(prod >>> Q_BITS);
                SUM: begin
                    a    <= alpha_r;
                    b    <= b_fit;
                    c    <= c_fit;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_clarke.sv
// Scoreboard bench for inv_clarke: driver pushes model results, monitor pops on done.
module tb_inv_clarke;

    localparam int DW = 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] alpha, beta;
    logic                 start;
    logic signed [DW-1:0] a, b, c;
    logic                 busy, done;

    typedef struct {
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        logic signed [DW-1:0] c;
        int                   acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_clarke dut (
        .clk  (clk),
        .rst  (rst),
        .alpha(alpha),
        .beta (beta),
        .start(start),
        .a    (a),
        .b    (b),
        .c    (c),
        .busy (busy),
        .done (done)
    );

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic signed [DW-1:0] fit(input longint v);
        longint t;
        t = v;
`ifdef INV_CLARKE_SAT_EN
        if (t > 131071) t = 131071;
        if (t < -131072) t = -131072;
`endif
        return DW'(t);
    endfunction

    function automatic exp_t model(input longint al, input longint be, input int acc);
        exp_t   e;
        longint h, p;
        h = fdiv(al, 2);
        p = fdiv(be * 28378, 32768);
        e.a = DW'(al);
        e.b = fit(p - h);
        e.c = fit(-p - h);
        e.acc_cyc = acc;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("done_without_request", done, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_a", a, e.a);
                check("out_b", b, e.b);
                check("out_c", c, e.c);
                check("latency", cyc - e.acc_cyc, 2);
            end
        end
    end

    // Issue one conversion at a negedge while idle; inputs are scrambled after acceptance.
    task automatic convert(input logic signed [DW-1:0] al, input logic signed [DW-1:0] be);
        int n;
        alpha = al;
        beta  = be;
        start = 1'b1;
        sb_q.push_back(model(al, be, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        alpha = DW'($urandom);
        beta  = DW'($urandom);
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        alpha = '0;
        beta  = '0;
        repeat (3) @(negedge clk);
        check("reset_a", a, 0);
        check("reset_b", b, 0);
        check("reset_c", c, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        convert(18'sd32768, 18'sd0);
        convert(18'sd0, 18'sd32768);
        convert(18'sd0, -18'sd32768);
        convert(-18'sd1, 18'sd0);
        convert(-18'sd131072, 18'sd131071);
        convert(18'sd131071, -18'sd131072);
        convert(-18'sd131072, -18'sd131072);
        convert(18'sd131071, 18'sd131071);

        for (int i = 0; i < 40; i++) convert(DW'($urandom), DW'($urandom));

        // start held high: one acceptance every third cycle
        for (int i = 0; i < 9; i++) begin
            alpha = DW'($urandom);
            beta  = DW'($urandom);
            start = 1'b1;
            check("busy_pattern", busy, (i % 3 != 0) ? 1 : 0);
            if (i % 3 == 0) sb_q.push_back(model(alpha, beta, cyc + 1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // second start during MUL is ignored
        alpha = 18'sd1000;
        beta  = 18'sd2000;
        start = 1'b1;
        sb_q.push_back(model(1000, 2000, cyc + 1));
        @(negedge clk);
        alpha = -18'sd5000;
        beta  = 18'sd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // reset during MUL aborts the conversion
        alpha = 18'sd40000;
        beta  = -18'sd30000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_a", a, 0);
        check("abort_b", b, 0);
        check("abort_c", c, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_idle", busy, 0);
        convert(18'sd12345, -18'sd6789);
        convert(-18'sd77777, 18'sd55555);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_clarke.md
Name: inv_clarke

Overview:
Inverse Clarke transform. Converts a stationary-frame vector (alpha, beta) back to three phase quantities (a, b, c) for the PWM/modulator stage. It is the return path of the forward Clarke block. A single shared multiplier is sequenced by a small FSM with a start/busy/done handshake.

Parameters:
D_WIDTH, 18, signed width of all data ports; Q_BITS+3, giving a range of -4.0 to +4.0.
Q_BITS, 15, number of fractional bits; 1.0 = 2**Q_BITS.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset; one clock, reset synchronous, active-high.
alpha  input  D_WIDTH  signed alpha component; sampled only on accepted start.
beta  input  D_WIDTH  signed beta component; sampled only on accepted start.
start  input  1  request conversion; accepted only when busy=0.
a  output  D_WIDTH  signed phase a result.
b  output  D_WIDTH  signed phase b result.
c  output  D_WIDTH  signed phase c result.
busy  output  1  high while in MUL or SUM.
done  output  1  one-cycle pulse; a, b and c are valid and newly updated.

Behaviour:
- Equations: a = alpha; b = p - h; c = -p - h.
  - h = alpha >>> 1 (arithmetic, floor).
  - p = (beta_r * K) >>> Q_BITS (arithmetic, floor).
  - K = round(0.86602540378 * 2**Q_BITS) = 28378 for Q_BITS=15.
- Product width: D_WIDTH+Q_BITS+1, signed. Sums are computed in D_WIDTH+2 bits before the output stage.
- FSM states: IDLE, MUL, SUM.
  - IDLE: on start=1, register alpha into alpha_r and beta into beta_r; go to MUL.
  - MUL: register p; go to SUM.
  - SUM: register a, b, c; done<=1; go to IDLE.
- Latency: start sampled at edge N; done=1 and outputs valid during the cycle after edge N+2.
- Throughput: one conversion per 3 cycles.
- busy = (state != IDLE), decoded from registered state.
- start while busy=1 is ignored; it is neither queued nor latched.
- done is high for exactly one cycle per conversion.
- a, b, c hold their last values until the next SUM. Input changes after acceptance have no effect.
- Output stage converts D_WIDTH+2 to D_WIDTH (see Optional Feature). a = alpha_r needs no conversion.
- Reset: when rst=1 at an edge, state<=IDLE and a, b, c, busy, done, alpha_r, beta_r, p all <=0.
  - Reset mid-conversion aborts the conversion; no done pulse is produced.
  - rst has priority over start in the same cycle.

Optional Feature:
INV_CLARKE_SAT_EN
- Defined: b and c saturate to [-(2**(D_WIDTH-1)), 2**(D_WIDTH-1)-1].
- Undefined: b and c are truncated to the low D_WIDTH bits (two's-complement wrap).
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package motor_ctrl_pkg holds:
  - Constant coefficients SQRT3_DIV_2 and ONE_DIV_SQRT3, each as a function of Q_BITS.
  - The state enum inv_clarke_state_t.
- One sub-module, sat_trunc, parameterised by IN_WIDTH/OUT_WIDTH. It contains the macro-controlled saturate-or-wrap logic and is instantiated for b and c.

Test Plan:
1. alpha=32768, beta=0, start pulse -> done 3 cycles later; a=32768, b=-16384, c=-16384.
2. alpha=0, beta=32768 -> a=0, b=28378, c=-28378. With beta=-32768 -> b=-28378, c=28378.
3. alpha=-1, beta=0 (floor rounding) -> a=-1, b=1, c=1.
4. alpha=-131072, beta=131071:
   - With INV_CLARKE_SAT_EN -> b=131071, c=-47975.
   - Without the macro -> b=-83097, c=-47975.
   - a=-131072 in both builds.
5. Handshake: start held high continuously -> busy pattern 0,1,1 repeating, done every third cycle. A second start issued during MUL is ignored; outputs reflect the first inputs only.
6. rst asserted during MUL -> next cycle busy=0, done=0, a=b=c=0, and no done pulse follows. A start after rst deassertion completes normally.
